mem_run_ctrl: RTL and testbench
===============================

Name: mem_run_ctrl

Overview:
- Sequences one delay-line memory manager test run:
  - holds the manager's run input low for a programmable settle period;
  - latches the manager's parameter word;
  - pre-fills every memory location with a seeded pattern through the replace-number write port;
  - releases the run into steady state.
- During the run, it pulls received/wrong-number reports from the manager through a one-deep buffer, acknowledges them, and forwards them to the UART transmit path with a valid/ready handshake.
- Sits between the host command decoder and the memory manager in the test harness.

Parameters:
- DATA_W, 16, width of one stored number.
- ADDR_W, 8, width of a memory address and of cfg_no_nums.
- PARAMS_W, 32, width of the manager parameter word.
- SETTLE_CYCLES, 64, clk cycles run is held low in SETTLE (>=1).
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE.
- stop  in  1  one-cycle pulse; ends a run from FILL or RUN.
- cfg_params  in  PARAMS_W  manager parameter word; sampled on accepted start.
- cfg_no_nums  in  ADDR_W  number of locations to fill; sampled on accepted start.
- cfg_seed  in  DATA_W  fill pattern seed; sampled on accepted start.
- cfg_fill_en  in  1  sampled on accepted start; 0 skips FILL.
- run  out  1  manager run/reset control.
- mem_params  out  PARAMS_W  latched parameter word.
- mem_replace_num  out  ADDR_W+DATA_W  {addr, data} replace packet.
- mem_replace_valid  out  1  replace write strobe.
- mem_received_num  in  ADDR_W+DATA_W  {addr, data} report from the manager.
- mem_received_replaced  in  1  report was a replaced number.
- mem_received_valid  in  1  report available.
- mem_received_overrun  in  1  manager-side overrun flag.
- mem_received_ack  out  1  one-cycle ack to the manager.
- msg_data  out  1+ADDR_W+DATA_W  {replaced, addr, data}.
- msg_valid  out  1  msg_data valid.
- msg_ready  in  1  UART tx accepts msg_data.
- busy  out  1  state != IDLE.
- err_count  out  ERR_W  saturating count of forwarded non-replaced reports.
- overrun_sticky  out  1  overrun seen during the run.

Behaviour:
- Reset values (async, n_reset low):
  - state=IDLE;
  - run, mem_replace_valid, mem_received_ack, msg_valid, busy, overrun_sticky = 0;
  - mem_params, mem_replace_num, msg_data, err_count = 0.
- All outputs are registered.
- IDLE:
  - run=0.
  - On start: latch cfg_*, clear err_count and overrun_sticky, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - run=0, mem_params=latched value.
  - Counter decrements each cycle; at 0 go to FILL if fill_en && no_nums!=0, else go to RUN.
  - run rises on the first cycle of the next state.
- FILL:
  - run=1.
  - One write per cycle: mem_replace_valid=1, addr=i, data=seed+i (mod 2^DATA_W), for i=0..no_nums-1.
  - After the write of i=no_nums-1, go to RUN.
  - Exactly no_nums strobes, on consecutive cycles.
  - Received reports are serviced here as in RUN.
- RUN:
  - run=1, no replace writes.
  - Stays until stop.
- Report capture (FILL, RUN, DRAIN):
  - Condition: mem_received_valid=1, buffer empty, mem_received_ack=0.
  - Action: capture {replaced, num} into msg_data, set msg_valid, pulse mem_received_ack for exactly the following cycle.
  - On capture with replaced=0, err_count increments, saturating at 2^ERR_W-1.
  - msg_valid holds until the cycle msg_valid && msg_ready; the buffer frees that cycle and can capture again on the next cycle.
  - If the buffer is full, no ack is sent; the manager keeps its report (it may flag overrun).
- overrun_sticky sets on any cycle with mem_received_overrun=1 while run=1; it clears only on start or reset.
- stop:
  - From FILL: abort the fill with no further strobes, go to DRAIN.
  - From RUN: go to DRAIN.
  - Ignored in IDLE, SETTLE and DRAIN.
  - A start pulse while busy is ignored.
- DRAIN:
  - run stays 1 until the buffer is empty (msg_valid=0) and no ack is pending.
  - Then run=0 and the state returns to IDLE; no capture occurs on that final cycle.
- Simultaneous start and stop in IDLE: start wins.
- Async reset mid-run drops run and all strobes immediately; any buffered message is discarded.

Test Plan:
- Fill sequence: start with no_nums=4, seed=0x0100, fill_en=1, SETTLE_CYCLES=64 -> run=0 for 64 cycles, then 4 consecutive strobes {0,0x0100}, {1,0x0101}, {2,0x0102}, {3,0x0103}, then RUN with busy=1.
- Fill skipped: no_nums=0 (or fill_en=0) -> SETTLE goes straight to RUN; zero replace strobes.
- Forward and ack: report {addr=2, data=0xBEEF, replaced=0} with msg_ready=1 -> msg_data={0,2,0xBEEF}, a single ack pulse, err_count=1. A replaced=1 report leaves err_count unchanged.
- Backpressure: msg_ready=0 while a second report arrives -> no second ack and msg_data held. Raise msg_ready -> the second report is captured one cycle after the handshake.
- Stop handling: stop at fill index 1 of no_nums=8 -> no strobes after index 1, and run falls once the pending message drains. Stop with msg_ready=0 -> run stays 1 until the handshake completes.
- Reset and saturation: n_reset low mid-FILL -> all outputs 0 asynchronously, IDLE. With ERR_W=2, 5 wrong reports -> err_count=3. A mem_received_overrun pulse -> overrun_sticky=1 until the next start.

Source files
------------

// File: rtl/mem_run_ctrl.sv
// -----------------------------------------------------------------------------
// mem_run_ctrl
//   Sequences one test run of the delay-line memory manager:
//     IDLE -> SETTLE (run held low) -> FILL (seeded pre-fill) -> RUN -> DRAIN.
//   During FILL/RUN it pulls received/wrong-number reports from the manager
//   through a one-deep buffer, acknowledges them, and forwards them to the UART
//   transmit path with a valid/ready handshake.
//
// Ports
//   clk, n_reset            clock, asynchronous active-low reset
//   start, stop             one-cycle control pulses from the host decoder
//   cfg_*                   run configuration, sampled on an accepted start
//   run                     manager run/reset control
//   mem_params              latched manager parameter word
//   mem_replace_num/_valid  {addr, data} pre-fill write port
//   mem_received_*          report interface from the manager (+ ack back)
//   msg_data/_valid/_ready  {replaced, addr, data} towards the UART tx path
//   busy                    any state other than IDLE
//   err_count               saturating count of forwarded non-replaced reports
//   overrun_sticky          manager overrun seen while run was high
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_run_ctrl #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 8,
  parameter int PARAMS_W      = 32,
  parameter int SETTLE_CYCLES = 64,
  parameter int ERR_W         = 16
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [PARAMS_W-1:0]        cfg_params,
  input  logic [ADDR_W-1:0]          cfg_no_nums,
  input  logic [DATA_W-1:0]          cfg_seed,
  input  logic                       cfg_fill_en,
  output logic                       run,
  output logic [PARAMS_W-1:0]        mem_params,
  output logic [ADDR_W+DATA_W-1:0]   mem_replace_num,
  output logic                       mem_replace_valid,
  input  logic [ADDR_W+DATA_W-1:0]   mem_received_num,
  input  logic                       mem_received_replaced,
  input  logic                       mem_received_valid,
  input  logic                       mem_received_overrun,
  output logic                       mem_received_ack,
  output logic [ADDR_W+DATA_W:0]     msg_data,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic                       busy,
  output logic [ERR_W-1:0]           err_count,
  output logic                       overrun_sticky
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  // Every register of the block, so next-state logic is a single r_d = f(r).
  typedef struct packed {
    state_t                     state;
    logic [CNT_W-1:0]           settle_cnt;
    logic [ADDR_W-1:0]          fill_idx;
    logic [ADDR_W-1:0]          no_nums;
    logic [DATA_W-1:0]          seed;
    logic                       fill_en;
    logic                       run;
    logic [PARAMS_W-1:0]        params;
    logic [ADDR_W+DATA_W-1:0]   replace_num;
    logic                       replace_valid;
    logic                       ack;
    logic [ADDR_W+DATA_W:0]     msg_data;
    logic                       msg_valid;
    logic                       busy;
    logic [ERR_W-1:0]           err_count;
    logic                       overrun;
  } regs_t;

  regs_t r, r_d;

  logic              capture;
  logic [ADDR_W-1:0] next_idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of process order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r <= '0;
    else          r <= r_d;
  end

  always_comb begin
    // NOTE: r_d starts as a copy of r so every field has a value on every path;
    // without this default, a field skipped in some branch would infer a latch.
    r_d      = r;
    r_d.ack  = 1'b0;
    next_idx = r.fill_idx + 1'b1;

    // Buffer frees on the handshake cycle; it can refill from the next cycle.
    if (r.msg_valid && msg_ready) r_d.msg_valid = 1'b0;

    // In DRAIN the exit condition (buffer empty, no ack pending) is exactly the
    // capture condition, so captures only ever happen in FILL and RUN.
    capture = (r.state == S_FILL || r.state == S_RUN) &&
              mem_received_valid && !r.msg_valid && !r.ack;

    if (capture) begin
      r_d.msg_data  = {mem_received_replaced, mem_received_num};
      r_d.msg_valid = 1'b1;
      r_d.ack       = 1'b1;
      if (!mem_received_replaced && (r.err_count != '1))
        r_d.err_count = r.err_count + 1'b1;
    end

    if (r.run && mem_received_overrun) r_d.overrun = 1'b1;

    unique case (r.state)
      S_IDLE: begin
        if (start) begin
          r_d.state      = S_SETTLE;
          r_d.settle_cnt = CNT_W'(SETTLE_CYCLES - 1);
          r_d.params     = cfg_params;
          r_d.no_nums    = cfg_no_nums;
          r_d.seed       = cfg_seed;
          r_d.fill_en    = cfg_fill_en;
          r_d.err_count  = '0;
          r_d.overrun    = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r.settle_cnt == '0) begin
          r_d.run = 1'b1;
          if (r.fill_en && (r.no_nums != '0)) begin
            r_d.state         = S_FILL;
            r_d.fill_idx      = '0;
            r_d.replace_num   = {{ADDR_W{1'b0}}, r.seed};
            r_d.replace_valid = 1'b1;
          end else begin
            r_d.state = S_RUN;
          end
        end else begin
          r_d.settle_cnt = r.settle_cnt - 1'b1;
        end
      end
      S_FILL: begin
        // fill_idx is the index of the strobe currently on the port.
        if (stop) begin
          r_d.replace_valid = 1'b0;
          r_d.state         = S_DRAIN;
        end else if (r.fill_idx == r.no_nums - 1'b1) begin
          r_d.replace_valid = 1'b0;
          r_d.state         = S_RUN;
        end else begin
          r_d.fill_idx    = next_idx;
          r_d.replace_num = {next_idx, r.seed + DATA_W'(next_idx)};
        end
      end
      S_RUN: begin
        if (stop) r_d.state = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r.msg_valid && !r.ack) begin
          r_d.run   = 1'b0;
          r_d.state = S_IDLE;
        end
      end
      default: r_d.state = S_IDLE;
    endcase

    r_d.busy = (r_d.state != S_IDLE);
  end

  assign run               = r.run;
  assign mem_params        = r.params;
  assign mem_replace_num   = r.replace_num;
  assign mem_replace_valid = r.replace_valid;
  assign mem_received_ack  = r.ack;
  assign msg_data          = r.msg_data;
  assign msg_valid         = r.msg_valid;
  assign busy              = r.busy;
  assign err_count         = r.err_count;
  assign overrun_sticky    = r.overrun;

endmodule

// File: tb/tb_mem_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_run_ctrl
//   Directed scenarios with literal expectations, followed by randomized
//   start/stop/report/backpressure traffic. A behavioural model, stepped on
//   each rising edge, predicts every output; a compare process checks the DUT
//   against it on every falling edge. The error counter is built 2 bits wide
//   so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_mem_run_ctrl;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;
  localparam int PARAMS_W = 32;
  localparam int SETTLE   = 64;
  localparam int ERR_W    = 2;
  localparam int ERR_MAX  = 3;

  logic                     clk;
  logic                     n_reset;
  logic                     start, stop;
  logic [PARAMS_W-1:0]      cfg_params;
  logic [ADDR_W-1:0]        cfg_no_nums;
  logic [DATA_W-1:0]        cfg_seed;
  logic                     cfg_fill_en;
  logic                     run;
  logic [PARAMS_W-1:0]      mem_params;
  logic [ADDR_W+DATA_W-1:0] mem_replace_num;
  logic                     mem_replace_valid;
  logic [ADDR_W+DATA_W-1:0] mem_received_num;
  logic                     mem_received_replaced;
  logic                     mem_received_valid;
  logic                     mem_received_overrun;
  logic                     mem_received_ack;
  logic [ADDR_W+DATA_W:0]   msg_data;
  logic                     msg_valid;
  logic                     msg_ready;
  logic                     busy;
  logic [ERR_W-1:0]         err_count;
  logic                     overrun_sticky;

  int checks = 0;
  int errors = 0;

  mem_run_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PARAMS_W(PARAMS_W),
    .SETTLE_CYCLES(SETTLE), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .stop(stop),
    .cfg_params(cfg_params), .cfg_no_nums(cfg_no_nums), .cfg_seed(cfg_seed),
    .cfg_fill_en(cfg_fill_en), .run(run), .mem_params(mem_params),
    .mem_replace_num(mem_replace_num), .mem_replace_valid(mem_replace_valid),
    .mem_received_num(mem_received_num),
    .mem_received_replaced(mem_received_replaced),
    .mem_received_valid(mem_received_valid),
    .mem_received_overrun(mem_received_overrun),
    .mem_received_ack(mem_received_ack), .msg_data(msg_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .busy(busy),
    .err_count(err_count), .overrun_sticky(overrun_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase of the run, settle cycles left, fill index on the
  // port, and the forwarding buffer as a queue.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_SETTLE, M_FILL, M_RUN, M_DRAIN} mphase_t;

  mphase_t                  m_phase;
  int                       m_settle_left, m_fill_i, m_no_nums;
  logic [DATA_W-1:0]        m_seed;
  bit                       m_fill_en;
  logic [ADDR_W+DATA_W:0]   m_buf[$];
  bit                       e_run, e_rvalid, e_ack, e_busy, e_ovr;
  logic [PARAMS_W-1:0]      e_params;
  logic [ADDR_W+DATA_W-1:0] e_rnum;
  int                       e_err;
  bit                       was_ack, had_msg, run_now;

  task automatic model_reset();
    m_phase = M_IDLE; m_settle_left = 0; m_fill_i = 0; m_no_nums = 0;
    m_seed = '0; m_fill_en = 0; m_buf.delete();
    e_run = 0; e_rvalid = 0; e_ack = 0; e_busy = 0; e_ovr = 0;
    e_params = '0; e_rnum = '0; e_err = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge n_reset);
      if (!n_reset) begin
        model_reset();
      end else begin
        was_ack = e_ack;
        had_msg = (m_buf.size() != 0);
        run_now = e_run;
        e_ack   = 0;
        if (had_msg && msg_ready) m_buf.delete(0);
        if ((m_phase == M_FILL || m_phase == M_RUN) && mem_received_valid &&
            !had_msg && !was_ack) begin
          m_buf.push_back({mem_received_replaced, mem_received_num});
          e_ack = 1;
          if (!mem_received_replaced && e_err < ERR_MAX) e_err++;
        end
        if (run_now && mem_received_overrun) e_ovr = 1;
        case (m_phase)
          M_IDLE: if (start) begin
            m_phase = M_SETTLE; m_settle_left = SETTLE;
            e_params = cfg_params; m_no_nums = int'(cfg_no_nums);
            m_seed = cfg_seed; m_fill_en = cfg_fill_en;
            e_err = 0; e_ovr = 0;
          end
          M_SETTLE: begin
            m_settle_left--;
            if (m_settle_left == 0) begin
              e_run = 1;
              if (m_fill_en && m_no_nums > 0) begin
                m_phase = M_FILL; m_fill_i = 0; e_rvalid = 1;
                e_rnum = {8'(0), m_seed};
              end else begin
                m_phase = M_RUN;
              end
            end
          end
          M_FILL: begin
            if (stop) begin
              e_rvalid = 0; m_phase = M_DRAIN;
            end else if (m_fill_i + 1 == m_no_nums) begin
              e_rvalid = 0; m_phase = M_RUN;
            end else begin
              m_fill_i++;
              e_rnum = {8'(m_fill_i), 16'(int'(m_seed) + m_fill_i)};
            end
          end
          M_RUN: if (stop) m_phase = M_DRAIN;
          M_DRAIN: if (!had_msg && !was_ack) begin
            e_run = 0; m_phase = M_IDLE;
          end
          default: m_phase = M_IDLE;
        endcase
        e_busy = (m_phase != M_IDLE);
      end
    end
  end

  // Compare process: every output, every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("run", 64'(run), 64'(e_run));
      check("busy", 64'(busy), 64'(e_busy));
      check("mem_params", 64'(mem_params), 64'(e_params));
      check("replace_valid", 64'(mem_replace_valid), 64'(e_rvalid));
      if (e_rvalid) check("replace_num", 64'(mem_replace_num), 64'(e_rnum));
      check("ack", 64'(mem_received_ack), 64'(e_ack));
      check("msg_valid", 64'(msg_valid), 64'(m_buf.size() != 0));
      if (m_buf.size() != 0) check("msg_data", 64'(msg_data), 64'(m_buf[0]));
      check("err_count", 64'(err_count), 64'(e_err));
      check("overrun_sticky", 64'(overrun_sticky), 64'(e_ovr));
    end
  end

  // One cycle; the manager withdraws its report once it sees the ack.
  task automatic tick();
    @(negedge clk);
    if (mem_received_ack) mem_received_valid = 1'b0;
  endtask

  task automatic report(input logic [7:0] addr, input logic [15:0] data,
                        input logic rep);
    mem_received_num      = {addr, data};
    mem_received_replaced = rep;
    mem_received_valid    = 1'b1;
  endtask

  logic [23:0] exp_fill [4];
  int low, n, strobes;

  initial begin
    exp_fill = '{24'h000100, 24'h010101, 24'h020102, 24'h030103};
    n_reset = 1'b0; start = 0; stop = 0; cfg_params = '0; cfg_no_nums = '0;
    cfg_seed = '0; cfg_fill_en = 0; mem_received_num = '0;
    mem_received_replaced = 0; mem_received_valid = 0;
    mem_received_overrun = 0; msg_ready = 0;
    repeat (3) tick();
    check("reset_run", 64'(run), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_msg", 64'({msg_valid, msg_data}), 0);
    n_reset = 1'b1;
    tick();

    // Fill sequence: 64 settle cycles, then four consecutive seeded strobes.
    cfg_params = 32'hCAFEF00D; cfg_no_nums = 8'd4; cfg_seed = 16'h0100;
    cfg_fill_en = 1; start = 1;
    tick();
    start = 0;
    low = 0;
    while (!run && low < 200) begin low++; tick(); end
    check("settle_low_cycles", 64'(low), 64);
    check("params_latched", 64'(mem_params), 64'h0CAFEF00D);
    for (int i = 0; i < 4; i++) begin
      check("fill_valid", 64'(mem_replace_valid), 1);
      check("fill_num", 64'(mem_replace_num), 64'(exp_fill[i]));
      tick();
    end
    check("fill_done", 64'(mem_replace_valid), 0);
    check("run_busy", 64'({run, busy}), 64'h3);

    // Forward and ack.
    msg_ready = 1;
    report(8'h02, 16'hBEEF, 0);
    tick();
    check("fwd_data", 64'(msg_data), 64'h002BEEF);
    check("fwd_ack", 64'({msg_valid, mem_received_ack}), 64'h3);
    check("fwd_err", 64'(err_count), 1);
    tick();
    check("ack_single", 64'(mem_received_ack), 0);
    report(8'h05, 16'h1234, 1);
    tick();
    check("replaced_data", 64'(msg_data), 64'h1051234);
    check("replaced_err", 64'(err_count), 1);
    tick();

    // Backpressure: second report waits for the handshake.
    msg_ready = 0;
    report(8'h03, 16'hAAAA, 0);
    tick();
    check("bp_first", 64'(msg_data), 64'h003AAAA);
    report(8'h04, 16'hBBBB, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_ack", 64'(mem_received_ack), 0);
      check("bp_held", 64'(msg_data), 64'h003AAAA);
    end
    msg_ready = 1;
    tick();
    check("bp_freed", 64'(msg_valid), 0);
    tick();
    check("bp_second", 64'(msg_data), 64'h004BBBB);
    check("bp_second_ack", 64'(mem_received_ack), 1);

    // Saturation: fifth non-replaced report.
    for (int i = 0; i < 2; i++) begin
      report(8'(6 + i), 16'h5A5A, 0);
      repeat (3) tick();
    end
    check("err_saturated", 64'(err_count), 3);

    // Overrun sticky.
    mem_received_overrun = 1;
    tick();
    mem_received_overrun = 0;
    check("overrun_set", 64'(overrun_sticky), 1);
    repeat (2) tick();
    check("overrun_held", 64'(overrun_sticky), 1);

    // Stop with a message stuck behind msg_ready=0.
    msg_ready = 0;
    report(8'h07, 16'h7777, 1);
    tick();
    stop = 1;
    tick();
    stop = 0;
    for (int i = 0; i < 4; i++) begin
      check("drain_run_high", 64'({run, busy}), 64'h3);
      tick();
    end
    msg_ready = 1;
    n = 0;
    while (run && n < 10) begin tick(); n++; end
    check("drain_exit_cycles", 64'(n), 2);
    check("drain_idle", 64'(busy), 0);

    // Start and stop together in IDLE; fill skipped with no_nums=0.
    cfg_no_nums = 8'd0; cfg_fill_en = 1; start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    check("start_wins", 64'(busy), 1);
    check("overrun_cleared", 64'(overrun_sticky), 0);
    strobes = 0; low = 0;
    while (!run && low < 200) begin
      if (mem_replace_valid) strobes++;
      low++; tick();
    end
    repeat (4) begin
      if (mem_replace_valid) strobes++;
      tick();
    end
    check("skip_low_cycles", 64'(low), 64);
    check("skip_strobes", 64'(strobes), 0);
    stop = 1;
    tick();
    stop = 0;
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    check("skip_stopped", 64'(busy), 0);

    // Stop at fill index 1 of 8 with a pending message.
    cfg_no_nums = 8'd8; cfg_seed = 16'h0200; msg_ready = 0; start = 1;
    tick();
    start = 0;
    report(8'h09, 16'h9999, 0);
    n = 0;
    while (!mem_replace_valid && n < 200) begin tick(); n++; end
    check("abort_fill_started", 64'(mem_replace_valid), 1);
    tick();
    check("abort_idx1", 64'(mem_replace_num), 64'h010201);
    stop = 1;
    tick();
    stop = 0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_replace_valid) strobes++;
      if (!run) strobes += 100;
      tick();
    end
    check("abort_no_strobes_run_high", 64'(strobes), 0);
    msg_ready = 1;
    n = 0;
    while (run && n < 10) begin tick(); n++; end
    check("abort_drained", 64'({run, busy}), 0);

    // Asynchronous reset in the middle of a fill.
    cfg_no_nums = 8'd8; start = 1;
    tick();
    start = 0;
    n = 0;
    while (!mem_replace_valid && n < 200) begin tick(); n++; end
    repeat (2) tick();
    #2 n_reset = 1'b0;
    #1;
    check("areset_outs", 64'({run, mem_replace_valid, mem_received_ack,
                              msg_valid, busy, overrun_sticky}), 0);
    check("areset_vals", 64'({mem_params, err_count}), 0);
    tick();
    n_reset = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      cfg_no_nums = 8'($urandom_range(0, 12));
      cfg_fill_en = ($urandom_range(0, 3) != 0);
      cfg_seed    = 16'($urandom);
      cfg_params  = $urandom;
      msg_ready   = ($urandom_range(0, 2) != 0);
      mem_received_overrun = ($urandom_range(0, 29) == 0);
      if (!mem_received_valid && $urandom_range(0, 3) == 0)
        report(8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    start = 0; stop = 0; mem_received_overrun = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
